// File: rtl/cache_refill_pkg.sv
// Shared types and constants for the cache refill arbiter.
package cache_refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_t;

    // Byte-offset bits of a line: word index bits plus two byte bits.
    function automatic int offset_bits(input int burst_len);
        return $clog2(burst_len) + 2;
    endfunction

    localparam int DEFAULT_BURST_LEN = 4;
    localparam int OFFSET_BITS       = offset_bits(DEFAULT_BURST_LEN);

endpackage

// File: rtl/cache_refill_arbiter_rr.sv
// Two-requester round-robin arbiter; remembers who was granted last.
module rr_arbiter_2
    import cache_refill_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output requester_t o_grant
);

    requester_t r_last_grant;

    // Pick a winner: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        o_valid = |i_req;
        o_grant = ICACHE;
        if (i_req[0] && i_req[1]) begin
            o_grant = (r_last_grant == ICACHE) ? DCACHE : ICACHE;
        end else if (i_req[1]) begin
            o_grant = DCACHE;
        end
    end

    // Record the winner only when the grant is actually taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= DCACHE;
        end else if (i_take && o_valid) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache, one burst at a time.
module cache_refill_arbiter
    import cache_refill_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 4
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_icache_req,
    input  logic [ADDR_WIDTH-1:0] i_icache_addr,
    output logic                  o_icache_gnt,
    output logic [DATA_WIDTH-1:0] o_icache_rdata,
    output logic                  o_icache_rdata_valid,
    output logic                  o_icache_done,
    input  logic                  i_dcache_req,
    input  logic                  i_dcache_write,
    input  logic [ADDR_WIDTH-1:0] i_dcache_addr,
    input  logic [DATA_WIDTH-1:0] i_dcache_wdata,
    output logic                  o_dcache_wdata_ack,
    output logic                  o_dcache_gnt,
    output logic [DATA_WIDTH-1:0] o_dcache_rdata,
    output logic                  o_dcache_rdata_valid,
    output logic                  o_dcache_done,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_rdata_valid
);

    localparam int LINE_OFFSET_BITS = offset_bits(BURST_LEN);
    localparam int CNT_W            = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~(ADDR_WIDTH'((1 << LINE_OFFSET_BITS) - 1));

    state_t                r_state;
    state_t                w_next_state;
    requester_t            r_owner;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [CNT_W-1:0]      r_ret_cnt;
    logic                  r_beat_term;
    logic                  r_ret_term;

    logic                  w_grant_valid;
    requester_t            w_grant_id;
    logic                  w_grant_take;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_handshake;
    logic                  w_read_active;
    logic                  w_return;
    logic                  w_last_beat;
    logic                  w_last_return;

    rr_arbiter_2 u_rr_arbiter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   ({i_dcache_req, i_icache_req}),
        .i_take  (w_grant_take),
        .o_valid (w_grant_valid),
        .o_grant (w_grant_id)
    );

    // Next-state decode plus every output; memory returns are steered in the same cycle.
    always_comb begin
        w_grant_take         = (r_state == IDLE) && w_grant_valid;
        w_sel_addr           = (w_grant_id == ICACHE) ? i_icache_addr : i_dcache_addr;
        w_handshake          = (r_state == ISSUE) && i_mem_ready;
        w_read_active        = ((r_state == ISSUE) || (r_state == DRAIN)) && !r_write;
        w_return             = w_read_active && i_mem_rdata_valid;
        w_last_beat          = w_handshake && (r_beat_cnt == LAST_IDX);
        w_last_return        = w_return && (r_ret_cnt == LAST_IDX);
        w_next_state         = r_state;

        o_mem_valid          = 1'b0;
        o_mem_write          = 1'b0;
        o_mem_addr           = '0;
        o_mem_wdata          = '0;
        o_icache_gnt         = 1'b0;
        o_dcache_gnt         = 1'b0;
        o_icache_rdata       = '0;
        o_icache_rdata_valid = 1'b0;
        o_dcache_rdata       = '0;
        o_dcache_rdata_valid = 1'b0;
        o_dcache_wdata_ack   = 1'b0;
        o_icache_done        = 1'b0;
        o_dcache_done        = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_take) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (w_last_beat) begin
                    if (r_write || r_ret_term || w_last_return) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_last_return || r_ret_term) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (r_state == ISSUE) begin
            o_mem_valid = 1'b1;
            o_mem_write = r_write;
            o_mem_addr  = r_base | ADDR_WIDTH'({r_beat_cnt, 2'b00});
            if (r_write) begin
                o_mem_wdata = i_dcache_wdata;
            end
        end

        if (r_state != IDLE) begin
            o_icache_gnt = (r_owner == ICACHE);
            o_dcache_gnt = (r_owner == DCACHE);
        end

        if (w_return) begin
            if (r_owner == ICACHE) begin
                o_icache_rdata_valid = 1'b1;
                o_icache_rdata       = i_mem_rdata;
            end else begin
                o_dcache_rdata_valid = 1'b1;
                o_dcache_rdata       = i_mem_rdata;
            end
        end

        o_dcache_wdata_ack = w_handshake && r_write && (r_owner == DCACHE);

        if (r_state == DONE) begin
            o_icache_done = (r_owner == ICACHE);
            o_dcache_done = (r_owner == DCACHE);
        end
    end

    // State register, grant latch and beat/return counters that saturate at the last index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_owner     <= ICACHE;
            r_write     <= 1'b0;
            r_base      <= '0;
            r_beat_cnt  <= '0;
            r_ret_cnt   <= '0;
            r_beat_term <= 1'b0;
            r_ret_term  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_take) begin
                r_owner     <= w_grant_id;
                r_write     <= (w_grant_id == DCACHE) && i_dcache_write;
                r_base      <= w_sel_addr & LINE_MASK;
                r_beat_cnt  <= '0;
                r_ret_cnt   <= '0;
                r_beat_term <= 1'b0;
                r_ret_term  <= 1'b0;
            end else begin
                if (w_handshake && !r_beat_term) begin
                    if (r_beat_cnt == LAST_IDX) begin
                        r_beat_term <= 1'b1;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                if (w_return && !r_ret_term) begin
                    if (r_ret_cnt == LAST_IDX) begin
                        r_ret_term <= 1'b1;
                    end else begin
                        r_ret_cnt <= r_ret_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
